// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Brief    : Shared types and geometry helpers for the write-through dcache.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } state_t;

   // Byte offset inside a 32-bit word
   localparam int c_WORD_OFF = 2;

   function automatic int tag_w(input int addr_w, input int idx_w);
      return addr_w - idx_w - c_WORD_OFF;
   endfunction

   function automatic int num_lines(input int idx_w);
      return 1 << idx_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_wt_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wt_responder_if
// Brief    : MEM-stage port plus external word-bus signals of the dcache.
// Revision : 1.0 - initial release
// ============================================================================
interface dcache_wt_responder_if #(
   parameter int ADDR_W = 32
);
   logic              memreadM;
   logic              memwriteM;
   logic [ADDR_W-1:0] aluoutM;
   logic [31:0]       writedataM;
   logic [31:0]       readdataM;
   logic              stallM;
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [31:0]       bus_wdata;
   logic              bus_ack;
   logic [31:0]       bus_rdata;

   // Environment side: drives the core request and the bus response
   modport master (
      output memreadM, memwriteM, aluoutM, writedataM, bus_ack, bus_rdata,
      input  readdataM, stallM, bus_req, bus_we, bus_addr, bus_wdata
   );

   // Cache side
   modport slave (
      input  memreadM, memwriteM, aluoutM, writedataM, bus_ack, bus_rdata,
      output readdataM, stallM, bus_req, bus_we, bus_addr, bus_wdata
   );
endinterface
`default_nettype wire

// File: rtl/dcache_tag_data_array.sv
`default_nettype none
// ============================================================================
// Module   : dcache_tag_data_array
// Brief    : Valid/tag/data storage; combinational read, synchronous write,
//            valid bits cleared asynchronously by rst (active-low).
// Revision : 1.0 - initial release
// ============================================================================
module dcache_tag_data_array
   import dcache_pkg::*;
#(
   parameter int IDX_W = 6,
   parameter int TAG_W = 24
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [IDX_W-1:0] i_rd_idx,
   output logic                  o_rd_valid,
   output logic      [TAG_W-1:0] o_rd_tag,
   output logic      [31:0]      o_rd_data,
   input  wire logic             i_wr_en,
   input  wire logic [IDX_W-1:0] i_wr_idx,
   input  wire logic [TAG_W-1:0] i_wr_tag,
   input  wire logic [31:0]      i_wr_data
);
   localparam int c_LINES = num_lines(IDX_W);

   logic [c_LINES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag  [c_LINES];
   logic [31:0]        r_data [c_LINES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
      end else if (i_wr_en) begin
         r_valid[i_wr_idx] <= 1'b1;
      end
   end

   // Tag and data carry no reset; the valid bit alone qualifies them
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/dcache_wt_responder.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wt_responder
// Brief    : Direct-mapped write-through, no-write-allocate data cache in
//            front of a slow word bus. Optional counters: DCACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_wt_responder
   import dcache_pkg::*;
#(
   parameter int IDX_W  = 6,
   parameter int ADDR_W = 32
) (
   input  wire logic             clk,
   input  wire logic             rst,
   dcache_wt_responder_if.slave  mem
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt,
   output logic [31:0]           wr_cnt
`endif
);
   localparam int c_TAG_W = tag_w(ADDR_W, IDX_W);

   state_t             r_state;
   state_t             w_state_nx;
   logic [IDX_W-1:0]   w_idx;
   logic [c_TAG_W-1:0] w_tag;
   logic               w_rd_valid;
   logic [c_TAG_W-1:0] w_rd_tag;
   logic [31:0]        w_rd_data;
   logic               w_match;
   logic               w_hit;
   logic               w_wr_en;
   logic [31:0]        w_wr_data;
   logic               w_unused;

   assign w_idx    = mem.aluoutM[IDX_W+c_WORD_OFF-1:c_WORD_OFF];
   assign w_tag    = mem.aluoutM[ADDR_W-1:IDX_W+c_WORD_OFF];
   assign w_unused = ^mem.aluoutM[c_WORD_OFF-1:0];
   assign w_match  = w_rd_valid && (w_rd_tag == w_tag);
   assign w_hit    = mem.memreadM && w_match;

   assign mem.bus_addr = {mem.aluoutM[ADDR_W-1:c_WORD_OFF], {c_WORD_OFF{1'b0}}};

   dcache_tag_data_array #(
      .IDX_W (IDX_W),
      .TAG_W (c_TAG_W)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .i_rd_idx   (w_idx),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_data  (w_rd_data),
      .i_wr_en    (w_wr_en),
      .i_wr_idx   (w_idx),
      .i_wr_tag   (w_tag),
      .i_wr_data  (w_wr_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      mem.stallM    = 1'b0;
      mem.readdataM = 32'd0;
      mem.bus_req   = 1'b0;
      mem.bus_we    = 1'b0;
      mem.bus_wdata = 32'd0;
      w_wr_en       = 1'b0;
      w_wr_data     = 32'd0;
      case (r_state)
         IDLE: begin
            // A store wins when both request lines are high
            if (mem.memwriteM) begin
               mem.stallM = 1'b1;
               w_state_nx = WR_THRU;
            end else if (mem.memreadM) begin
               if (w_hit) begin
                  mem.readdataM = w_rd_data;
               end else begin
                  mem.stallM = 1'b1;
                  w_state_nx = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            mem.bus_req = 1'b1;
            if (mem.bus_ack) begin
               mem.readdataM = mem.bus_rdata;
               w_wr_en       = 1'b1;
               w_wr_data     = mem.bus_rdata;
               w_state_nx    = IDLE;
            end else begin
               mem.stallM = 1'b1;
            end
         end
         WR_THRU: begin
            mem.bus_req   = 1'b1;
            mem.bus_we    = 1'b1;
            mem.bus_wdata = mem.writedataM;
            if (mem.bus_ack) begin
               // Refresh a resident line only; misses never allocate
               w_wr_en    = w_match;
               w_wr_data  = mem.writedataM;
               w_state_nx = IDLE;
            end else begin
               mem.stallM = 1'b1;
            end
         end
         default: w_state_nx = IDLE;
      endcase
      // Hold every output quiet while reset is asserted
      if (!rst) begin
         mem.stallM    = 1'b0;
         mem.readdataM = 32'd0;
         mem.bus_req   = 1'b0;
         mem.bus_we    = 1'b0;
         mem.bus_wdata = 32'd0;
         w_wr_en       = 1'b0;
      end
   end

`ifdef DCACHE_STATS_EN
   logic w_hit_evt;
   logic w_miss_evt;
   logic w_wr_evt;

   assign w_hit_evt  = (r_state == IDLE) && !mem.memwriteM && w_hit;
   assign w_miss_evt = (r_state == IDLE) && (w_state_nx == RD_MISS);
   assign w_wr_evt   = (r_state == IDLE) && (w_state_nx == WR_THRU);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt  <= 32'd0;
         miss_cnt <= 32'd0;
         wr_cnt   <= 32'd0;
      end else begin
         if (w_hit_evt)  hit_cnt  <= hit_cnt + 32'd1;
         if (w_miss_evt) miss_cnt <= miss_cnt + 32'd1;
         if (w_wr_evt)   wr_cnt   <= wr_cnt + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_wt_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_wt_responder
// Brief    : Self-checking bench for dcache_wt_responder (vector table,
//            read-data scoreboard, reset/late-ack sequence).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_wt_responder;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] brdata;
      int          delay;
      int          exp_stall;
      logic [31:0] exp_rdata;
      logic        exp_bus;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   dcache_wt_responder_if #(.ADDR_W(32)) m ();

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
   logic [31:0] wr_cnt;
`endif

   dcache_wt_responder #(
      .IDX_W  (6),
      .ADDR_W (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mem (m.slave)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt),
      .wr_cnt   (wr_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      m.memreadM   = 1'b0;
      m.memwriteM  = 1'b0;
      m.aluoutM    = 32'd0;
      m.writedataM = 32'd0;
      m.bus_ack    = 1'b0;
      m.bus_rdata  = 32'd0;
   endtask

   task automatic do_access(input string name, input vec_t v);
      int          reqs;
      int          cyc;
      int          stalls;
      logic        done;
      logic [31:0] got;
      logic [31:0] exp;
      reqs   = 0;
      cyc    = 0;
      stalls = 0;
      done   = 1'b0;
      got    = 32'd0;
      @(posedge clk); #1;
      m.memreadM   = v.rd;
      m.memwriteM  = v.wr;
      m.aluoutM    = v.addr;
      m.writedataM = v.wdata;
      sb.push_back(v.exp_rdata);
      while (!done && cyc < 40) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
         end
         m.bus_ack = 1'b0;
         if (m.bus_req) begin
            if (reqs == v.delay) begin
               m.bus_ack   = 1'b1;
               m.bus_rdata = v.brdata;
            end
            reqs++;
            chk({name, ".bus_we"}, {31'd0, m.bus_we}, {31'd0, v.wr});
            chk({name, ".bus_addr"}, m.bus_addr, v.addr & 32'hFFFF_FFFC);
            if (v.wr) chk({name, ".bus_wdata"}, m.bus_wdata, v.wdata);
         end
         @(negedge clk);
         if (!m.stallM) begin
            done = 1'b1;
            got  = m.readdataM;
         end else begin
            stalls++;
         end
         cyc++;
      end
      chk({name, ".complete"}, {31'd0, done}, 32'd1);
      chk({name, ".stall_cycles"}, stalls, v.exp_stall);
      chk({name, ".bus_used"}, {31'd0, (reqs > 0)}, {31'd0, v.exp_bus});
      exp = sb.pop_front();
      chk({name, ".readdataM"}, got, exp);
      @(posedge clk); #1;
      idle_inputs();
   endtask

   vec_t tbl[12];
   vec_t v;
   int   exp_hits;
   int   exp_miss;
   int   exp_wr;

   initial begin
      //          rd wr addr           wdata          brdata         dly st  exp_rdata      bus
      tbl[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 3, 4, 32'hDEAD_BEEF, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h0,         0, 0, 32'hDEAD_BEEF, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0,         0, 1, 32'h0,         1'b1};
      tbl[3]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h0,         0, 0, 32'h1234_5678, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 32'h0000_0080, 32'hAAAA_5555, 32'h0,         1, 2, 32'h0,         1'b1};
      tbl[5]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         32'h0,         0, 0, 32'h0BAD_F00D, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 32'h0000_0140, 32'h0,         32'h1111_2222, 2, 3, 32'h1111_2222, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 0, 1, 32'h1234_5678, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 32'h0000_0042, 32'h0,         32'h0,         0, 0, 32'h1234_5678, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 32'h0000_0140, 32'h0,         32'h1111_2222, 0, 1, 32'h1111_2222, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 32'h0000_0147, 32'h5A5A_5A5A, 32'h0,         2, 3, 32'h0,         1'b1};

      idle_inputs();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.stallM", {31'd0, m.stallM}, 32'd0);
      chk("reset.bus_req", {31'd0, m.bus_req}, 32'd0);
      chk("reset.bus_we", {31'd0, m.bus_we}, 32'd0);
      chk("reset.readdataM", m.readdataM, 32'd0);
      rst = 1'b1;

      exp_hits = 0;
      exp_miss = 0;
      exp_wr   = 0;
      for (int i = 0; i < 12; i++) begin
         do_access($sformatf("vec%0d", i), tbl[i]);
         if (tbl[i].wr)           exp_wr++;
         else if (tbl[i].exp_bus) exp_miss++;
         else                     exp_hits++;
      end
`ifdef DCACHE_STATS_EN
      chk("stats.hit_cnt", hit_cnt, exp_hits);
      chk("stats.miss_cnt", miss_cnt, exp_miss);
      chk("stats.wr_cnt", wr_cnt, exp_wr);
`endif

      // Reset in the middle of a read miss, then a stale ack afterwards
      @(posedge clk); #1;
      m.memreadM = 1'b1;
      m.aluoutM  = 32'h0000_0200;
      @(posedge clk); #1;
      chk("rstmiss.bus_req_before", {31'd0, m.bus_req}, 32'd1);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk("rstmiss.stallM", {31'd0, m.stallM}, 32'd0);
      chk("rstmiss.bus_req", {31'd0, m.bus_req}, 32'd0);
      chk("rstmiss.bus_we", {31'd0, m.bus_we}, 32'd0);
      chk("rstmiss.readdataM", m.readdataM, 32'd0);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      m.bus_ack   = 1'b1;
      m.bus_rdata = 32'h0000_0099;
      @(negedge clk);
      chk("lateack.bus_req", {31'd0, m.bus_req}, 32'd0);
      chk("lateack.stallM", {31'd0, m.stallM}, 32'd0);
      @(posedge clk); #1;
      m.bus_ack = 1'b0;
      @(negedge clk);
      chk("lateack.bus_req_after", {31'd0, m.bus_req}, 32'd0);

      v = '{1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_0001, 32'h0, 0, 1, 32'h0, 1'b1};
      do_access("both_rd_wr", v);
`ifdef DCACHE_STATS_EN
      chk("stats2.wr_cnt", wr_cnt, 32'd1);
      chk("stats2.miss_cnt", miss_cnt, 32'd0);
      chk("stats2.hit_cnt", hit_cnt, 32'd0);
`endif
      v = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D, 1'b1};
      do_access("postrst_80", v);
      v = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 1, 32'h1234_5678, 1'b1};
      do_access("postrst_40", v);
      v = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0077, 1, 2, 32'h0000_0077, 1'b1};
      do_access("noalloc_10", v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/dcache_wt_responder.md
Name: dcache_wt_responder

Overview:
- Data-memory responder that terminates the pipeline's MEM-stage port (memwriteM, aluoutM, writedataM, readdataM) and sits between the core and a slow external word bus.
- Direct-mapped, one-word-per-line, write-through, no-write-allocate cache.
- Load hits return data in the same cycle.
- Load misses and all stores assert stallM until the external bus completes. The hazard unit uses stallM to freeze the F/D/E/M stages.

Parameters:
- IDX_W, 6, index bits; the cache has 2**IDX_W lines.
- ADDR_W, 32, byte-address width from the core.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- memreadM  in  1  load request from MEM stage.
- memwriteM  in  1  store request from MEM stage.
- aluoutM  in  ADDR_W  byte address; bits [1:0] ignored.
- writedataM  in  32  store data.
- readdataM  out  32  load data.
- stallM  out  1  core must hold the MEM-stage request stable while this is high.
- bus_req  out  1  external request valid.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  word-aligned address ({aluoutM[ADDR_W-1:2],2'b00}).
- bus_wdata  out  32  write data.
- bus_ack  in  1  one-cycle completion pulse.
- bus_rdata  in  32  read data, valid with bus_ack.

Behaviour:
- Address split: index = aluoutM[IDX_W+1:2]; tag = aluoutM[ADDR_W-1:IDX_W+2].
- Storage per line: valid bit, tag, data word.
- Hit = memreadM & valid[index] & (tag == tag_arr[index]).
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - Load hit: readdataM = data_arr[index] combinationally, stallM = 0, state unchanged.
  - Load miss: stallM = 1 combinationally in the same cycle; next state RD_MISS.
  - Store: stallM = 1 combinationally; next state WR_THRU.
  - memreadM and memwriteM both high: treated as a store (store has priority).
- RD_MISS:
  - bus_req = 1, bus_we = 0, stallM = 1.
  - On bus_ack: fill line (valid = 1, tag, data = bus_rdata) at the clock edge; readdataM = bus_rdata combinationally in the ack cycle; stallM = 0 in the ack cycle; next state IDLE.
- WR_THRU:
  - bus_req = 1, bus_we = 1, bus_wdata = writedataM, stallM = 1.
  - On bus_ack: if the tag matches a valid line, update that line's data (no allocate on miss); stallM = 0; next state IDLE.
- Bus rule: bus_req, bus_we, bus_addr and bus_wdata stay stable from request until bus_ack. bus_ack while bus_req = 0 is ignored.
- Minimum latency:
  - Load miss: 2 cycles (request cycle plus ack cycle when bus_ack arrives the next cycle).
  - Store: same as load miss.
  - Load hit: 0 extra cycles.
- Outputs when idle or not a load: readdataM = 0 when no load is in progress. bus_req = 0 in IDLE.
- Reset, asserted asynchronously at any time including mid-miss or mid-store:
  - state = IDLE; all valid bits = 0; stallM = 0; bus_req = 0; bus_we = 0; readdataM = 0.
  - Tag and data arrays are not reset.
  - Any outstanding bus transaction is abandoned; a late bus_ack in IDLE is ignored.
- Back-to-back accesses: the request following a completed miss is evaluated in IDLE on the next cycle. There is no hit-under-miss.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined: adds outputs hit_cnt[31:0], miss_cnt[31:0], wr_cnt[31:0].
  - hit_cnt increments on every non-stalled load hit.
  - miss_cnt increments on entry to RD_MISS.
  - wr_cnt increments on entry to WR_THRU.
  - All counters are 0 on reset and wrap modulo 2^32.
- When not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dcache_pkg holds: state enum (IDLE, RD_MISS, WR_THRU), IDX_W/tag-width derivation functions, word-offset constant 2.
- One sub-module: dcache_tag_data_array, which holds the valid/tag/data arrays. It provides a combinational read and a synchronous write, and an async valid-clear on rst.

Test Plan:
- Reset then load 0x0000_0040, bus returns 0xDEAD_BEEF after 3 cycles -> stallM high for 4 cycles, readdataM = 0xDEAD_BEEF in the ack cycle; repeat the load -> hit, stallM = 0, no bus_req.
- Store 0x1234_5678 to 0x40 (line present) -> bus_we = 1, bus_wdata = 0x1234_5678 held until ack; then load 0x40 -> hit returning 0x1234_5678.
- Store to 0x80 (line absent) -> write-through only; next load 0x80 -> miss (no allocate).
- Conflict: load 0x40 then load 0x140 (same index, different tag) -> second is a miss and evicts; load 0x40 again -> miss.
- Assert rst mid-RD_MISS, then send bus_ack after deassert -> state IDLE, bus_req = 0, ack ignored, all prior lines miss.
- memreadM and memwriteM both high at 0x10 -> WR_THRU taken; with DCACHE_STATS_EN, wr_cnt = 1, miss_cnt = 0.
